dram_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single DRAM memory port between NUM_REQ line-sized requesters, such as L2 slices or a writeback buffer.
- Latches one request, drives the DRAM with a single-cycle mem_rd/mem_wr strobe, holds address and write data until mem_ready, then returns read data and a done pulse to the owner.
- Sits between the L2/writeback logic and the dram model.

---
 rtl/dram_arbiter_pkg.sv | 20 ++
 rtl/dram_arbiter_rr_pick.sv | 34 +++
 rtl/dram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the DRAM port arbiter.
package dram_arbiter_pkg;

    localparam int L2_LINE_SIZE    = 64;   // bytes per cache line
    localparam int DEFAULT_TIMEOUT = 255;  // WAIT cycles before timeout_err
    localparam int TMO_W           = 8;    // timeout counter width (max 255)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Saturating increment for the WAIT-cycle counter.
    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past rr_ptr and
// wraps, so the most recent owner has the lowest priority.
module rr_pick
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Walk NUM_REQ candidates starting after rr_ptr; the first pending one wins.
    always_comb begin
        int c;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        c      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (int'(rr_ptr) + i) % NUM_REQ;
            if (!valid && pending[IDX_W'(c)]) begin
                valid              = 1'b1;
                winner[IDX_W'(c)]  = 1'b1;
                idx                = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter and sequencer sharing one DRAM port between NUM_REQ
// line-sized requesters. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int LINE_SIZE = L2_LINE_SIZE,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    localparam int LINE_BITS = LINE_SIZE * 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_rd,
    input  logic [NUM_REQ-1:0]           req_wr,
    input  logic [NUM_REQ*32-1:0]        req_addr,
    input  logic [NUM_REQ*LINE_BITS-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_gnt,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [LINE_BITS-1:0]         req_rdata,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [31:0]                  mem_addr,
    output logic [LINE_BITS-1:0]         mem_wdata,
    output logic                         mem_rd,
    output logic                         mem_wr,
    input  logic [LINE_BITS-1:0]         mem_rdata,
    input  logic                         mem_ready
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     owner_q, owner_d;
    logic                   is_wr_q, is_wr_d;
    logic [31:0]            addr_q, addr_d;
    logic [LINE_BITS-1:0]   wdata_q, wdata_d;
    logic [LINE_BITS-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic                   busy_q, busy_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   tmo_err_q, tmo_err_d;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [31:0]            sel_addr;
    logic [LINE_BITS-1:0]   sel_wdata;
    logic                   sel_wr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .pending (req_rd | req_wr),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick_onehot),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    // Route the winning requester's address, data and op (write wins over read).
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_addr  = req_addr[32*k +: 32];
                sel_wdata = req_wdata[LINE_BITS*k +: LINE_BITS];
                sel_wr    = req_wr[k];
            end
        end
    end

    // Next-state and next-output logic; strobes and pulses default low each cycle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        gnt_d     = '0;
        done_d    = '0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d  = pick_onehot;
                    rr_ptr_d = pick_idx;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    is_wr_d  = sel_wr;
                    gnt_d    = pick_onehot;
                    mem_rd_d = !sel_wr;
                    mem_wr_d = sel_wr;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready) begin
                    tmo_cnt_d = '0;
                    done_d    = owner_q;
                    if (!is_wr_q) rdata_d = mem_rdata;
                    state_d   = ST_RESP;
                end else begin
                    // The DRAM may still complete, so a timeout only flags.
                    tmo_cnt_d = sat_inc(tmo_cnt_q);
                    if (tmo_cnt_d >= TMO_LIM) tmo_err_d = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            busy_q    <= busy_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign req_gnt     = gnt_q;
    assign req_done    = done_q;
    assign req_rdata   = rdata_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_err_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a LATENCY=10 DRAM model on the main
// instance, and a second instance with TIMEOUT=5 whose ready is hand-driven.
module tb_dram_arbiter;

    localparam int NR = 2;
    localparam int LB = 512;
    localparam int L  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance signals
    logic [NR-1:0]    req_rd = '0, req_wr = '0;
    logic [NR*32-1:0] req_addr = '0;
    logic [NR*LB-1:0] req_wdata = '0;
    logic [NR-1:0]    req_gnt, req_done;
    logic [LB-1:0]    req_rdata, mem_wdata, mem_rdata;
    logic             busy, timeout_err, mem_rd, mem_wr, mem_ready;
    logic [31:0]      mem_addr;

    // Timeout instance signals
    logic [NR-1:0]    to_req_rd = '0, to_req_wr = '0;
    logic [NR*32-1:0] to_req_addr = '0;
    logic [NR*LB-1:0] to_req_wdata = '0;
    logic [NR-1:0]    to_gnt, to_done;
    logic [LB-1:0]    to_rdata, to_mem_wdata, to_mem_rdata;
    logic             to_busy, to_err, to_mem_rd, to_mem_wr;
    logic             to_ready = 1'b0;
    logic [31:0]      to_mem_addr;
    assign to_mem_rdata = {(LB/8){8'h11}};

    dram_arbiter #(.NUM_REQ(NR), .LINE_SIZE(64)) u_dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .req_done(req_done), .req_rdata(req_rdata),
        .busy(busy), .timeout_err(timeout_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    dram_arbiter #(.NUM_REQ(NR), .LINE_SIZE(64), .TIMEOUT(5)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_rd(to_req_rd), .req_wr(to_req_wr), .req_addr(to_req_addr), .req_wdata(to_req_wdata),
        .req_gnt(to_gnt), .req_done(to_done), .req_rdata(to_rdata),
        .busy(to_busy), .timeout_err(to_err),
        .mem_addr(to_mem_addr), .mem_wdata(to_mem_wdata), .mem_rd(to_mem_rd), .mem_wr(to_mem_wr),
        .mem_rdata(to_mem_rdata), .mem_ready(to_ready)
    );

    // DRAM model: strobe starts an L-cycle countdown; data moves at completion.
    logic [LB-1:0] dram_mem [16];
    logic          dram_clr = 1'b1;
    int            dcnt;
    logic          dop_wr;
    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (dram_clr) begin
            for (int i = 0; i < 16; i++) dram_mem[i] <= '0;
            dram_mem[1] <= {448'h0, 64'hDEACBEEECAFFBABF};
            dcnt      <= 0;
            dop_wr    <= 1'b0;
            mem_rdata <= '0;
        end else if (mem_rd || mem_wr) begin
            dcnt   <= L;
            dop_wr <= mem_wr;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 1) begin
            dcnt      <= 0;
            mem_ready <= 1'b1;
            if (dop_wr) dram_mem[mem_addr[9:6]] <= mem_wdata;
            else        mem_rdata <= dram_mem[mem_addr[9:6]];
        end
    end

    // Strobe monitor, sampled away from the active edge.
    int rd_pulses = 0, wr_pulses = 0, both_cnt = 0, done_cnt = 0, ready_cnt = 0;
    int rd_run = 0, wr_run = 0, max_run = 0;
    always @(negedge clk) begin
        if (mem_rd) begin rd_pulses++; rd_run++; end else rd_run = 0;
        if (mem_wr) begin wr_pulses++; wr_run++; end else wr_run = 0;
        if (rd_run > max_run) max_run = rd_run;
        if (wr_run > max_run) max_run = wr_run;
        if (mem_rd && mem_wr) both_cnt++;
        if (req_done != '0) done_cnt++;
        if (mem_ready) ready_cnt++;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request on requester k and follow it to req_done (bounded).
    task automatic run_txn(input int k, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [LB-1:0] wdata,
                           output int gnt_rel, output int done_rel,
                           output logic [NR-1:0] gnt_v, output logic [NR-1:0] done_v,
                           output logic [LB-1:0] rdata);
        int n;
        @(negedge clk);
        req_rd[k] = rd;
        req_wr[k] = wr;
        req_addr[32*k +: 32]  = addr;
        req_wdata[LB*k +: LB] = wdata;
        n = 0; gnt_rel = -1; done_rel = -1;
        gnt_v = '0; done_v = '0; rdata = '0;
        while (done_rel < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (req_gnt != '0 && gnt_rel < 0) begin
                gnt_rel = n;
                gnt_v   = req_gnt;
                req_rd[k] = 1'b0;
                req_wr[k] = 1'b0;
            end
            if (req_done != '0) begin
                done_rel = n;
                done_v   = req_done;
                rdata    = req_rdata;
            end
        end
        req_rd[k] = 1'b0;
        req_wr[k] = 1'b0;
    endtask

    initial begin
        int gr, dr, n, ng, rd_b, wr_b, dn_b, rdy_b;
        logic [NR-1:0] gv, dv;
        logic [LB-1:0] rdat;
        logic [NR-1:0] glog [4];
        int            gt   [4];
        logic [LB-1:0] a5_line, c3_line;
        a5_line = {(LB/8){8'hA5}};
        c3_line = {(LB/8){8'h3C}};

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dram_clr = 1'b0;
        @(negedge clk);
        check("rst_busy", LB'(busy), LB'(0));
        check("rst_pulses", LB'({req_gnt, req_done, mem_rd, mem_wr, timeout_err}), LB'(0));
        check("rst_mem_addr", LB'(mem_addr), LB'(0));
        check("rst_to_inst", LB'({to_gnt, to_busy, to_err, to_mem_rd}), LB'(0));

        // Single read on requester 0
        rd_b = rd_pulses; wr_b = wr_pulses;
        run_txn(0, 1'b1, 1'b0, 32'h40, '0, gr, dr, gv, dv, rdat);
        check("rd_gnt_cycle", LB'(gr), LB'(1));
        check("rd_gnt_vec", LB'(gv), LB'(2'b01));
        check("rd_done_cycle", LB'(dr), LB'(13));
        check("rd_done_vec", LB'(dv), LB'(2'b01));
        check("rd_data", LB'(rdat[63:0]), LB'(64'hDEACBEEECAFFBABF));
        check("rd_mem_rd_cnt", LB'(rd_pulses - rd_b), LB'(1));
        check("rd_mem_wr_cnt", LB'(wr_pulses - wr_b), LB'(0));

        // Write then read on requester 1
        wr_b = wr_pulses;
        run_txn(1, 1'b0, 1'b1, 32'h80, a5_line, gr, dr, gv, dv, rdat);
        check("wr_gnt_vec", LB'(gv), LB'(2'b10));
        check("wr_done_vec", LB'(dv), LB'(2'b10));
        check("wr_mem_wr_cnt", LB'(wr_pulses - wr_b), LB'(1));
        run_txn(1, 1'b1, 1'b0, 32'h80, '0, gr, dr, gv, dv, rdat);
        check("wr_rd_done_cycle", LB'(dr), LB'(13));
        check("wr_rd_data", rdat, a5_line);

        // rd+wr together: write wins
        rd_b = rd_pulses; wr_b = wr_pulses;
        run_txn(0, 1'b1, 1'b1, 32'hC0, c3_line, gr, dr, gv, dv, rdat);
        check("rw_mem_wr_cnt", LB'(wr_pulses - wr_b), LB'(1));
        check("rw_mem_rd_cnt", LB'(rd_pulses - rd_b), LB'(0));
        check("rw_dram_line", dram_mem[3], c3_line);
        check("rw_rdata_kept", req_rdata, a5_line);

        // Reset three cycles after grant, while in WAIT
        @(negedge clk);
        req_rd[0] = 1'b1;
        req_addr[31:0] = 32'h40;
        n = 0;
        while (req_gnt == '0 && n < 10) begin @(negedge clk); n++; end
        req_rd[0] = 1'b0;
        check("rw_rst_gnt_seen", LB'(req_gnt), LB'(2'b01));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rdy_b = ready_cnt;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", LB'(busy), LB'(0));
        check("mid_rst_pulses", LB'({req_gnt, req_done, mem_rd, mem_wr, timeout_err}), LB'(0));
        check("mid_rst_addr", LB'(mem_addr), LB'(0));
        check("mid_rst_wdata", mem_wdata, LB'(0));
        check("mid_rst_rdata", req_rdata, LB'(0));
        dn_b = done_cnt;
        repeat (20) @(negedge clk);
        check("stale_ready_seen", LB'(ready_cnt - rdy_b), LB'(1));
        check("stale_ready_no_done", LB'(done_cnt - dn_b), LB'(0));
        check("stale_ready_idle", LB'(busy), LB'(0));

        // Contention: both requesters hold reads for four grants
        rd_b = rd_pulses;
        @(negedge clk);
        req_addr = {32'h80, 32'h40};
        req_rd   = 2'b11;
        n = 0; ng = 0;
        for (int i = 0; i < 4; i++) begin glog[i] = '0; gt[i] = 0; end
        while (ng < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (req_gnt != '0) begin glog[ng] = req_gnt; gt[ng] = n; ng++; end
        end
        req_rd = '0;
        n = 0;
        while (req_done == '0 && n < 30) begin @(negedge clk); n++; end
        check("cont_grants", LB'(ng), LB'(4));
        check("cont_order", LB'({glog[0], glog[1], glog[2], glog[3]}), LB'(8'b01_10_01_10));
        check("cont_space01", LB'(gt[1] - gt[0]), LB'(14));
        check("cont_space12", LB'(gt[2] - gt[1]), LB'(14));
        check("cont_space23", LB'(gt[3] - gt[2]), LB'(14));
        check("cont_mem_rd_cnt", LB'(rd_pulses - rd_b), LB'(4));
        check("strobe_max_run", LB'(max_run), LB'(1));
        check("strobe_both", LB'(both_cnt), LB'(0));

        // Timeout instance: TIMEOUT=5, ready withheld
        @(negedge clk);
        to_req_rd[0] = 1'b1;
        to_req_addr[31:0] = 32'h100;
        n = 0;
        while (to_gnt == '0 && n < 10) begin @(negedge clk); n++; end
        to_req_rd[0] = 1'b0;
        check("to_gnt", LB'(to_gnt), LB'(2'b01));
        repeat (5) @(negedge clk);
        check("to_err_before", LB'(to_err), LB'(0));
        @(negedge clk);
        check("to_err_set", LB'(to_err), LB'(1));
        check("to_busy_wait", LB'(to_busy), LB'(1));
        repeat (4) @(negedge clk);
        check("to_busy_later", LB'(to_busy), LB'(1));
        to_ready = 1'b1;
        @(negedge clk);
        to_ready = 1'b0;
        check("to_late_done", LB'(to_done), LB'(2'b01));
        check("to_late_rdata", to_rdata, to_mem_rdata);
        check("to_err_sticky", LB'(to_err), LB'(1));
        @(negedge clk);
        check("to_idle_busy", LB'(to_busy), LB'(0));
        check("to_err_still", LB'(to_err), LB'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
